// File: rtl/ldst_mem_arbiter.sv
// ldst_mem_arbiter: round-robin arbiter that shares one memory port between LDST pipes.
// Grants stay locked for a whole segment burst; load responses are steered back by ID.
module ldst_mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_LOG   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_load_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output logic                      mem_load_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_data_o,
    output logic [REQ_LOG-1:0]        mem_id_o,
    input  logic                      mem_rvalid_i,
    input  logic [REQ_LOG-1:0]        mem_rid_i,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    output logic [DATA_W-1:0]         resp_data_o,
    output logic                      busy_o,
    output logic                      err_o
);
    localparam logic IDLE  = 1'b0;
    localparam logic BURST = 1'b1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic                state_q, state_d;
    logic [REQ_LOG-1:0]  rr_q, rr_d;
    logic [REQ_LOG-1:0]  grant_q, grant_d;
    logic [3:0]          outst_q, outst_d;
    logic                err_q, err_d;
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic [REQ_LOG-1:0]  pick, idx;
    logic                found, credit, hs, inc, dec;

    // First valid pipe at or above rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        pick  = rr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_q + REQ_LOG'(i);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign credit      = outst_q < 4'(MAX_OUTST);
    assign mem_valid_o = (state_q == BURST) && req_valid_i[grant_q] && (!req_load_i[grant_q] || credit);
    assign hs          = mem_valid_o && mem_ready_i;
    assign req_ready_o = hs ? ONE << grant_q : '0;
    assign mem_load_o  = req_load_i[grant_q];
    assign mem_addr_o  = req_addr_i[grant_q*ADDR_W +: ADDR_W];
    assign mem_data_o  = req_data_i[grant_q*DATA_W +: DATA_W];
    assign mem_id_o    = grant_q;
    assign inc         = hs && req_load_i[grant_q];
    assign dec         = mem_rvalid_i;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (state_q == IDLE) begin
            if (|req_valid_i) begin
                grant_d = pick;
                state_d = BURST;
            end
        end else if (hs && req_last_i[grant_q]) begin
            rr_d    = grant_q + REQ_LOG'(1);
            state_d = IDLE;
        end
    end

    // A response with nothing outstanding is flagged but never underflows the counter.
    assign outst_d      = (inc && !dec) ? outst_q + 4'd1 :
                          (!inc && dec && outst_q != 4'd0) ? outst_q - 4'd1 : outst_q;
    assign err_d        = err_q | (dec && outst_q == 4'd0);
    assign resp_valid_d = mem_rvalid_i ? ONE << mem_rid_i : '0;
    assign resp_data_d  = mem_rvalid_i ? mem_rdata_i : resp_data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            outst_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            outst_q      <= outst_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign busy_o       = (state_q != IDLE) || (outst_q != 4'd0);
    assign err_o        = err_q;
endmodule
